phase_detector_stats: RTL and testbench
=======================================

PHASE_DETECTOR_STATS -- requirements
Module: phase_detector_stats

Interface
REQ-001 Parameter PHASE_W, default 32: NCO phase width.
REQ-002 Parameter ERR_W, default 16: phase error width, ERR_W <= PHASE_W.
REQ-003 Parameter AVG_LOG2, default 3: averaging window of 2^AVG_LOG2 edges.
REQ-004 Parameter CNT_W, default 16: zone statistics counter width.
REQ-005 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  sole clock, all logic on posedge.
REQ-007 reset  in  1  async active-high reset.
REQ-008 enable  in  1  high: edges processed; low: edges ignored.
REQ-009 edge_detected  in  1  one-cycle strobe, flux edge seen this cycle.
REQ-010 nco_phase  in  PHASE_W  NCO phase sampled with edge_detected.
REQ-011 thresh_near  in  ERR_W  unsigned on-time magnitude limit.
REQ-012 thresh_far  in  ERR_W  unsigned way-off magnitude limit.
REQ-013 stats_clear  in  1  sync clear of averaging and counters.
REQ-014 phase_error  out  ERR_W  signed error of last accepted edge.
REQ-015 error_valid  out  1  one-cycle pulse, phase_error/margin_zone updated.
REQ-016 margin_zone  out  2  01 on-time, 10 marginal, 11 way-off.
REQ-017 avg_error  out  ERR_W  signed mean error of last full window.
REQ-018 avg_valid  out  1  one-cycle pulse, avg_error updated.
REQ-019 cnt_ontime / cnt_marginal / cnt_wayoff  out  CNT_W each  per-zone edge counts.

Function
REQ-020 Accepted edge = edge_detected & enable, sampled at posedge N.
REQ-021 phase_error SHALL be nco_phase[PHASE_W-1 -: ERR_W] as two's complement, registered at N+1 (positive = early, negative = late).
REQ-022 error_valid SHALL pulse high exactly at N+1 per accepted edge, else 0; back-to-back edges give back-to-back pulses.
REQ-023 Magnitude |e| computed in ERR_W+1 bits; most-negative code (0x8000) yields 0x8000, no overflow.
REQ-024 Zone priority: |e| >= thresh_far -> 11; else |e| >= thresh_near -> 10; else 01; thresholds sampled at N; thresh_near > thresh_far makes marginal unreachable, no error.
REQ-025 phase_error and margin_zone SHALL hold between accepted edges; enable low freezes all state except stats_clear.
REQ-026 Accumulator width ERR_W+AVG_LOG2, signed, plus AVG_LOG2-bit edge counter; each accepted edge adds its error at N+1.
REQ-027 On the 2^AVG_LOG2-th edge: avg_error = total >>> AVG_LOG2 (arithmetic, floor) and avg_valid pulses at N+2; accumulator and counter restart with no gap edge.
REQ-028 Zone counters increment at N+1 for the edge's zone and SHALL saturate at all-ones (no wrap).
REQ-029 stats_clear at cycle N zeroes accumulator, window counter and zone counters at N+1; an accepted edge in the same cycle still produces phase_error/error_valid but SHALL NOT be counted or accumulated; avg_error holds.
REQ-030 An in-flight avg_valid (N+2) from an edge before stats_clear SHALL still fire.

Reset
REQ-031 Reset SHALL asynchronously force phase_error=0, error_valid=0, margin_zone=01, avg_error=0, avg_valid=0, all counters, accumulator and pipeline stages =0.
REQ-032 Reset mid-window discards partial sums; first avg after release covers only post-reset edges.

Structure
REQ-033 Package phase_detector_pkg SHALL hold zone encodings (ZONE_ONTIME=01, ZONE_MARGINAL=10, ZONE_WAYOFF=11) and default parameter constants.
REQ-034 One sub-module sat_counter (CNT_W, inc, clr) SHALL be instantiated three times for zone counters.

Verification (defaults, thresh_near=0x2000, thresh_far=0x4000)
REQ-035 Reset release, no edges -> error_valid=0, margin_zone=01, avg_valid=0, counters=0.
REQ-036 Edges 0x10000000, 0xF0000000 -> phase_error 0x1000 then 0xF000, zone 01 both, error_valid one cycle each.
REQ-037 Edges 0x1FFFFFFF, 0x20000000, 0x40000000, 0xC0000000, 0x80000000 -> zones 01, 10, 11, 11, 11.
REQ-038 After stats_clear, 8 back-to-back edges i*0x10000000 (i=0..7) -> avg_error 0x3800, avg_valid one cycle after 8th error_valid; counts 2/2/4.
REQ-039 stats_clear coincident with edge 0x50000000 -> error_valid=1, phase_error 0x5000, counters 0 next cycle.
REQ-040 Reset after 5 edges, then 8 edges of 0x08000000 -> avg_error 0x0800, cnt_ontime=8; with CNT_W=3, 9 on-time edges -> cnt_ontime=7.

Source files
------------

// File: rtl/phase_detector_pkg.sv
// Shared definitions for the phase detector statistics block: margin zone
// encodings and the default parameter set.
package phase_detector_pkg;

    localparam int DEF_PHASE_W  = 32;
    localparam int DEF_ERR_W    = 16;
    localparam int DEF_AVG_LOG2 = 3;
    localparam int DEF_CNT_W    = 16;

    typedef enum logic [1:0] {
        ZONE_ONTIME   = 2'b01,
        ZONE_MARGINAL = 2'b10,
        ZONE_WAYOFF   = 2'b11
    } zone_t;

endpackage

// File: rtl/phase_detector_stats_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of
// wrapping so a long run of edges never reads back as a small count.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, stop at all-ones; clear wins over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/phase_detector_stats.sv
// Phase detector statistics: turns the NCO phase sampled at each flux edge
// into a signed phase error, classifies it into a margin zone, keeps
// saturating per-zone counts and a block average over 2^AVG_LOG2 edges.
module phase_detector_stats
    import phase_detector_pkg::*;
#(
    parameter int PHASE_W  = DEF_PHASE_W,
    parameter int ERR_W    = DEF_ERR_W,
    parameter int AVG_LOG2 = DEF_AVG_LOG2,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               edge_detected,
    input  logic [PHASE_W-1:0] nco_phase,
    input  logic [ERR_W-1:0]   thresh_near,
    input  logic [ERR_W-1:0]   thresh_far,
    input  logic               stats_clear,
    output logic [ERR_W-1:0]   phase_error,
    output logic               error_valid,
    output logic [1:0]         margin_zone,
    output logic [ERR_W-1:0]   avg_error,
    output logic               avg_valid,
    output logic [CNT_W-1:0]   cnt_ontime,
    output logic [CNT_W-1:0]   cnt_marginal,
    output logic [CNT_W-1:0]   cnt_wayoff
);

    localparam int ACC_W = ERR_W + AVG_LOG2;
    localparam logic [ERR_W:0] MAG_ONE = (ERR_W + 1)'(1);

    logic                    accept;
    logic                    count_en;
    logic [ERR_W-1:0]        err_in;
    logic [ERR_W:0]          err_mag;
    zone_t                   zone_in;
    logic                    unused_phase;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] win_sum_q;
    logic [AVG_LOG2-1:0]     win_cnt_q;
    logic                    win_done;
    logic                    avg_pend_q;

    assign accept   = edge_detected & enable;
    // An edge coincident with stats_clear is reported but never counted.
    assign count_en = accept & ~stats_clear;
    // The phase MSBs are the error: near 0 is on time, the wrap point is
    // half a bit cell off in either direction.
    assign err_in   = nco_phase[PHASE_W-1 -: ERR_W];
    // Phase LSBs below the error resolution are deliberately dropped.
    assign unused_phase = ^nco_phase;

    // Magnitude in one extra bit so the most-negative code folds without
    // overflow, then classify far before near so far always wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        err_mag = {1'b0, err_in};
        zone_in = ZONE_ONTIME;
        if (err_in[ERR_W-1]) begin
            err_mag = ~{1'b1, err_in} + MAG_ONE;
        end
        if (err_mag >= {1'b0, thresh_far}) begin
            zone_in = ZONE_WAYOFF;
        end else if (err_mag >= {1'b0, thresh_near}) begin
            zone_in = ZONE_MARGINAL;
        end
    end

    // Register the error and zone of each accepted edge; hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            phase_error <= '0;
            margin_zone <= ZONE_ONTIME;
            error_valid <= 1'b0;
        end else begin
            error_valid <= accept;
            if (accept) begin
                phase_error <= err_in;
                margin_zone <= zone_in;
            end
        end
    end

    // Running window sum and edge count; the last edge of a window hands the
    // complete sum to the averaging stage and restarts the window at zero.
    assign acc_sum  = acc_q + {{AVG_LOG2{err_in[ERR_W-1]}}, err_in};
    assign win_done = count_en & (win_cnt_q == '1);

    // Window accumulation, restart and hand-off of the finished sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            win_cnt_q  <= '0;
            win_sum_q  <= '0;
            avg_pend_q <= 1'b0;
        end else begin
            avg_pend_q <= win_done;
            if (stats_clear) begin
                acc_q     <= '0;
                win_cnt_q <= '0;
            end else if (accept) begin
                win_cnt_q <= win_cnt_q + 1'b1;
                acc_q     <= win_done ? '0 : acc_sum;
                if (win_done) begin
                    win_sum_q <= acc_sum;
                end
            end
        end
    end

    // Averaging stage: arithmetic shift gives the floored mean. A pending
    // result still lands even if stats_clear arrived in between.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avg_error <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= avg_pend_q;
            if (avg_pend_q) begin
                avg_error <= ERR_W'(win_sum_q >>> AVG_LOG2);
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_ontime (
        .clk   (clk),
        .reset (reset),
        .inc   (count_en && (zone_in == ZONE_ONTIME)),
        .clr   (stats_clear),
        .count (cnt_ontime)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_marginal (
        .clk   (clk),
        .reset (reset),
        .inc   (count_en && (zone_in == ZONE_MARGINAL)),
        .clr   (stats_clear),
        .count (cnt_marginal)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_wayoff (
        .clk   (clk),
        .reset (reset),
        .inc   (count_en && (zone_in == ZONE_WAYOFF)),
        .clr   (stats_clear),
        .count (cnt_wayoff)
    );

endmodule

// File: tb/tb_phase_detector_stats.sv
// Self-checking bench for phase_detector_stats. A behavioural model keeps the
// list of accepted errors in the open window and per-zone event totals since
// the last clear; directed scenarios and a randomized run compare against it.
module tb_phase_detector_stats;

    localparam int CNT_MAX  = 65535;
    localparam int CNT3_MAX = 7;
    localparam int WINDOW   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, edge_detected, stats_clear;
    logic [31:0] nco_phase;
    logic [15:0] thresh_near, thresh_far;

    logic [15:0] phase_error, avg_error, cnt_ontime, cnt_marginal, cnt_wayoff;
    logic        error_valid, avg_valid;
    logic [1:0]  margin_zone;

    logic [15:0] s_phase_error, s_avg_error;
    logic        s_error_valid, s_avg_valid;
    logic [1:0]  s_margin_zone;
    logic [2:0]  s_cnt_ontime, s_cnt_marginal, s_cnt_wayoff;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    logic [15:0] exp_pe, exp_avg, avg_pend_val;
    logic        exp_ev, exp_avg_valid, avg_pend;
    logic [1:0]  exp_zone;
    int          zone_events [4];
    int          window [$];

    phase_detector_stats dut (
        .clk(clk), .reset(reset), .enable(enable), .edge_detected(edge_detected),
        .nco_phase(nco_phase), .thresh_near(thresh_near), .thresh_far(thresh_far),
        .stats_clear(stats_clear), .phase_error(phase_error), .error_valid(error_valid),
        .margin_zone(margin_zone), .avg_error(avg_error), .avg_valid(avg_valid),
        .cnt_ontime(cnt_ontime), .cnt_marginal(cnt_marginal), .cnt_wayoff(cnt_wayoff)
    );

    phase_detector_stats #(.CNT_W(3)) dut_small (
        .clk(clk), .reset(reset), .enable(enable), .edge_detected(edge_detected),
        .nco_phase(nco_phase), .thresh_near(thresh_near), .thresh_far(thresh_far),
        .stats_clear(stats_clear), .phase_error(s_phase_error), .error_valid(s_error_valid),
        .margin_zone(s_margin_zone), .avg_error(s_avg_error), .avg_valid(s_avg_valid),
        .cnt_ontime(s_cnt_ontime), .cnt_marginal(s_cnt_marginal), .cnt_wayoff(s_cnt_wayoff)
    );

    function automatic logic [1:0] zone_of(input int err);
        int mag;
        mag = (err < 0) ? -err : err;
        if (mag >= int'(thresh_far)) return 2'b11;
        if (mag >= int'(thresh_near)) return 2'b10;
        return 2'b01;
    endfunction

    function automatic int sat(input int events, input int max);
        return (events > max) ? max : events;
    endfunction

    task automatic model_reset();
        exp_pe = '0; exp_avg = '0; exp_ev = 1'b0; exp_avg_valid = 1'b0;
        exp_zone = 2'b01; avg_pend = 1'b0; avg_pend_val = '0;
        zone_events = '{default: 0};
        window.delete();
    endtask

    // Drive one cycle of stimulus, wait past the edge, and advance the model
    // to what the outputs must show after that edge.
    task automatic apply(input bit e, input bit en, input logic [31:0] ph, input bit clr);
        logic signed [15:0] e16;
        int err, sum, avg;
        logic [1:0] z;
        edge_detected = e; enable = en; nco_phase = ph; stats_clear = clr;
        @(posedge clk);
        #1;
        exp_avg_valid = avg_pend;
        if (avg_pend) exp_avg = avg_pend_val;
        avg_pend = 1'b0;
        e16 = ph[31:16];
        err = e16;
        z   = zone_of(err);
        exp_ev = e && en;
        if (e && en) begin
            exp_pe = ph[31:16];
            exp_zone = z;
        end
        if (clr) begin
            window.delete();
            zone_events = '{default: 0};
        end else if (e && en) begin
            zone_events[z] = zone_events[z] + 1;
            window.push_back(err);
            if (window.size() == WINDOW) begin
                sum = 0;
                foreach (window[k]) sum += window[k];
                avg = (sum >= 0) ? sum / WINDOW : -((-sum + WINDOW - 1) / WINDOW);
                avg_pend_val = avg[15:0];
                avg_pend = 1'b1;
                window.delete();
            end
        end
        edge_detected = 1'b0; stats_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (3) apply(0, 1, 32'h0, 0);
        n_vec++; if (error_valid !== 1'b0) begin n_err++; $display("FAIL reset_error_valid: got %b want 0", error_valid); end
        n_vec++; if (margin_zone !== 2'b01) begin n_err++; $display("FAIL reset_zone: got %b want 01", margin_zone); end
        n_vec++; if (avg_valid !== 1'b0) begin n_err++; $display("FAIL reset_avg_valid: got %b want 0", avg_valid); end
        n_vec++; if (phase_error !== 16'h0) begin n_err++; $display("FAIL reset_phase_error: got %h want 0000", phase_error); end
        n_vec++; if (avg_error !== 16'h0) begin n_err++; $display("FAIL reset_avg_error: got %h want 0000", avg_error); end
        n_vec++; if ({cnt_ontime, cnt_marginal, cnt_wayoff} !== 48'h0) begin
            n_err++; $display("FAIL reset_counters: got %h/%h/%h want 0/0/0", cnt_ontime, cnt_marginal, cnt_wayoff);
        end
    endtask

    task automatic test_basic();
        logic [31:0] phases [2];
        phases[0] = 32'h1000_0000;
        phases[1] = 32'hF000_0000;
        for (int i = 0; i < 2; i++) begin
            apply(1, 1, phases[i], 0);
            n_vec++; if (error_valid !== 1'b1) begin n_err++; $display("FAIL basic_ev_%0d: got %b want 1", i, error_valid); end
            n_vec++; if (phase_error !== exp_pe) begin n_err++; $display("FAIL basic_pe_%0d: got %h want %h", i, phase_error, exp_pe); end
            n_vec++; if (margin_zone !== 2'b01) begin n_err++; $display("FAIL basic_zone_%0d: got %b want 01", i, margin_zone); end
            apply(0, 1, 32'h0, 0);
            n_vec++; if (error_valid !== 1'b0) begin n_err++; $display("FAIL basic_ev_drop_%0d: got %b want 0", i, error_valid); end
            n_vec++; if (phase_error !== exp_pe) begin n_err++; $display("FAIL basic_hold_%0d: got %h want %h", i, phase_error, exp_pe); end
        end
    endtask

    task automatic test_zones();
        logic [31:0] phases [5];
        logic [1:0]  zones  [5];
        phases = '{32'h1FFF_FFFF, 32'h2000_0000, 32'h4000_0000, 32'hC000_0000, 32'h8000_0000};
        zones  = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11};
        for (int i = 0; i < 5; i++) begin
            apply(1, 1, phases[i], 0);
            n_vec++; if (margin_zone !== zones[i]) begin n_err++; $display("FAIL zone_%h: got %b want %b", phases[i], margin_zone, zones[i]); end
            n_vec++; if (margin_zone !== exp_zone) begin n_err++; $display("FAIL zone_model_%h: got %b want %b", phases[i], margin_zone, exp_zone); end
            apply(0, 1, 32'h0, 0);
        end
    endtask

    task automatic test_average();
        apply(0, 1, 32'h0, 1);
        for (int i = 0; i < 8; i++) begin
            apply(1, 1, 32'(i) << 28, 0);
            n_vec++; if (error_valid !== 1'b1) begin n_err++; $display("FAIL avg_ev_%0d: got %b want 1", i, error_valid); end
            n_vec++; if (avg_valid !== 1'b0) begin n_err++; $display("FAIL avg_early_%0d: got %b want 0", i, avg_valid); end
        end
        n_vec++; if ({cnt_ontime, cnt_marginal, cnt_wayoff} !== {16'd2, 16'd2, 16'd4}) begin
            n_err++; $display("FAIL avg_counts: got %0d/%0d/%0d want 2/2/4", cnt_ontime, cnt_marginal, cnt_wayoff);
        end
        apply(0, 1, 32'h0, 0);
        n_vec++; if (avg_valid !== 1'b1) begin n_err++; $display("FAIL avg_valid: got %b want 1", avg_valid); end
        n_vec++; if (avg_error !== 16'h3800) begin n_err++; $display("FAIL avg_value: got %h want 3800", avg_error); end
        apply(0, 1, 32'h0, 0);
        n_vec++; if (avg_valid !== 1'b0) begin n_err++; $display("FAIL avg_pulse_width: got %b want 0", avg_valid); end
        n_vec++; if (avg_error !== 16'h3800) begin n_err++; $display("FAIL avg_hold: got %h want 3800", avg_error); end
    endtask

    task automatic test_clear_coincident();
        for (int i = 0; i < 8; i++) apply(1, 1, 32'h0100_0000, 0);
        apply(1, 1, 32'h5000_0000, 1);
        n_vec++; if (error_valid !== 1'b1) begin n_err++; $display("FAIL clr_ev: got %b want 1", error_valid); end
        n_vec++; if (phase_error !== 16'h5000) begin n_err++; $display("FAIL clr_pe: got %h want 5000", phase_error); end
        n_vec++; if ({cnt_ontime, cnt_marginal, cnt_wayoff} !== 48'h0) begin
            n_err++; $display("FAIL clr_counters: got %0d/%0d/%0d want 0/0/0", cnt_ontime, cnt_marginal, cnt_wayoff);
        end
        n_vec++; if (avg_valid !== 1'b1) begin n_err++; $display("FAIL clr_inflight_avg: got %b want 1", avg_valid); end
        n_vec++; if (avg_error !== 16'h0100) begin n_err++; $display("FAIL clr_inflight_val: got %h want 0100", avg_error); end
        for (int i = 0; i < 8; i++) apply(1, 1, 32'h0200_0000, 0);
        apply(0, 1, 32'h0, 0);
        n_vec++; if (avg_valid !== 1'b1 || avg_error !== 16'h0200) begin
            n_err++; $display("FAIL clr_next_window: got %b/%h want 1/0200", avg_valid, avg_error);
        end
    endtask

    task automatic test_enable();
        logic [15:0] held_pe, held_on;
        held_pe = phase_error;
        held_on = cnt_ontime;
        apply(1, 0, 32'h7000_0000, 0);
        n_vec++; if (error_valid !== 1'b0) begin n_err++; $display("FAIL en_ev: got %b want 0", error_valid); end
        n_vec++; if (phase_error !== held_pe) begin n_err++; $display("FAIL en_pe_hold: got %h want %h", phase_error, held_pe); end
        n_vec++; if (cnt_ontime !== held_on || cnt_wayoff !== 16'(zone_events[3])) begin
            n_err++; $display("FAIL en_cnt_hold: got %0d/%0d want %0d/%0d", cnt_ontime, cnt_wayoff, held_on, zone_events[3]);
        end
        apply(0, 0, 32'h0, 1);
        n_vec++; if (cnt_ontime !== 16'h0) begin n_err++; $display("FAIL en_clear: got %0d want 0", cnt_ontime); end
    endtask

    task automatic test_reset_mid_window();
        for (int i = 0; i < 5; i++) apply(1, 1, 32'h3000_0000, 0);
        reset = 1'b1;
        #2;
        n_vec++; if (phase_error !== 16'h0 || margin_zone !== 2'b01) begin
            n_err++; $display("FAIL async_reset: got %h/%b want 0000/01", phase_error, margin_zone);
        end
        n_vec++; if (cnt_wayoff !== 16'h0) begin n_err++; $display("FAIL async_reset_cnt: got %0d want 0", cnt_wayoff); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) apply(1, 1, 32'h0800_0000, 0);
        n_vec++; if (cnt_ontime !== 16'd8) begin n_err++; $display("FAIL post_reset_cnt: got %0d want 8", cnt_ontime); end
        apply(1, 1, 32'h0800_0000, 0);
        n_vec++; if (avg_valid !== 1'b1 || avg_error !== 16'h0800) begin
            n_err++; $display("FAIL post_reset_avg: got %b/%h want 1/0800", avg_valid, avg_error);
        end
        n_vec++; if (s_cnt_ontime !== 3'd7) begin n_err++; $display("FAIL sat_cnt3: got %0d want 7", s_cnt_ontime); end
        n_vec++; if (cnt_ontime !== 16'd9) begin n_err++; $display("FAIL wide_cnt9: got %0d want 9", cnt_ontime); end
    endtask

    task automatic test_random();
        logic [31:0] ph;
        logic [15:0] r16;
        bit e, en, clr;
        for (int i = 0; i < 600; i++) begin
            if (i % 75 == 0) begin
                thresh_near = 16'($urandom_range(0, 16'h7FFF));
                thresh_far  = 16'($urandom_range(0, 16'hFFFF));
            end
            r16 = 16'($urandom());
            case ($urandom_range(0, 4))
                0: ph = {thresh_near, r16};
                1: ph = {thresh_far, r16};
                2: ph = {~thresh_near + 16'd1, r16};
                3: ph = {16'h8000, r16};
                default: ph = $urandom();
            endcase
            e   = ($urandom_range(0, 99) < 60);
            en  = ($urandom_range(0, 99) < 85);
            clr = ($urandom_range(0, 99) < 3);
            apply(e, en, ph, clr);
            n_vec++; if (error_valid !== exp_ev) begin n_err++; $display("FAIL rnd_ev %0d: got %b want %b", i, error_valid, exp_ev); end
            n_vec++; if (phase_error !== exp_pe) begin n_err++; $display("FAIL rnd_pe %0d: got %h want %h", i, phase_error, exp_pe); end
            n_vec++; if (margin_zone !== exp_zone) begin n_err++; $display("FAIL rnd_zone %0d: got %b want %b", i, margin_zone, exp_zone); end
            n_vec++; if (avg_valid !== exp_avg_valid) begin n_err++; $display("FAIL rnd_avg_valid %0d: got %b want %b", i, avg_valid, exp_avg_valid); end
            n_vec++; if (avg_error !== exp_avg) begin n_err++; $display("FAIL rnd_avg %0d: got %h want %h", i, avg_error, exp_avg); end
            n_vec++; if (cnt_ontime !== 16'(sat(zone_events[1], CNT_MAX))) begin n_err++; $display("FAIL rnd_on %0d: got %0d want %0d", i, cnt_ontime, zone_events[1]); end
            n_vec++; if (cnt_marginal !== 16'(sat(zone_events[2], CNT_MAX))) begin n_err++; $display("FAIL rnd_mg %0d: got %0d want %0d", i, cnt_marginal, zone_events[2]); end
            n_vec++; if (cnt_wayoff !== 16'(sat(zone_events[3], CNT_MAX))) begin n_err++; $display("FAIL rnd_wo %0d: got %0d want %0d", i, cnt_wayoff, zone_events[3]); end
            n_vec++; if (s_cnt_ontime !== 3'(sat(zone_events[1], CNT3_MAX))) begin n_err++; $display("FAIL rnd_s_on %0d: got %0d want %0d", i, s_cnt_ontime, sat(zone_events[1], CNT3_MAX)); end
            n_vec++; if (s_cnt_marginal !== 3'(sat(zone_events[2], CNT3_MAX))) begin n_err++; $display("FAIL rnd_s_mg %0d: got %0d want %0d", i, s_cnt_marginal, sat(zone_events[2], CNT3_MAX)); end
            n_vec++; if (s_cnt_wayoff !== 3'(sat(zone_events[3], CNT3_MAX))) begin n_err++; $display("FAIL rnd_s_wo %0d: got %0d want %0d", i, s_cnt_wayoff, sat(zone_events[3], CNT3_MAX)); end
            n_vec++; if ({s_error_valid, s_phase_error, s_margin_zone} !== {exp_ev, exp_pe, exp_zone}) begin
                n_err++; $display("FAIL rnd_s_err %0d: got %b/%h/%b want %b/%h/%b", i, s_error_valid, s_phase_error, s_margin_zone, exp_ev, exp_pe, exp_zone);
            end
            n_vec++; if ({s_avg_valid, s_avg_error} !== {exp_avg_valid, exp_avg}) begin
                n_err++; $display("FAIL rnd_s_avg %0d: got %b/%h want %b/%h", i, s_avg_valid, s_avg_error, exp_avg_valid, exp_avg);
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; edge_detected = 1'b0; stats_clear = 1'b0;
        nco_phase = '0; thresh_near = 16'h2000; thresh_far = 16'h4000;
        model_reset();
        test_reset();
        test_basic();
        test_zones();
        test_average();
        test_clear_coincident();
        test_enable();
        test_reset_mid_window();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
